iter_shift_ctrl: RTL
====================

Name: iter_shift_ctrl

Overview:
- Multi-cycle right shifter controller. Reuses one shared shift step (shift by 2, or by 1 for an odd remainder) on each cycle to perform a full 0..WIDTH-1 right shift.
- Selectable logical (zero fill) or arithmetic (sign fill) shift.
- Sits between an issuing unit and the consumer of the result. Uses valid/ready handshakes on both sides and trades latency for area against a full barrel shifter.

Parameters:
- WIDTH, 16, datapath width in bits.
- AMTW, 4, shift-amount width; must satisfy 2**AMTW == WIDTH.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- in_data  in  WIDTH  operand.
- in_amt  in  AMTW  shift amount, 0..WIDTH-1.
- in_arith  in  1  1 = sign fill from operand MSB, 0 = zero fill.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  shifted result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous on rst_n low): state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_data = 0, remaining count = 0, fill mode = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch in_data into the working register, in_amt into remaining, in_arith into fill mode.
  - Next state is SHIFT if in_amt != 0, otherwise DONE.
- SHIFT:
  - Each cycle, if remaining >= 2: shift the working register right by 2 and decrement remaining by 2.
  - Otherwise: shift right by 1 and decrement remaining by 1.
  - Vacated MSBs take the register's current MSB when fill mode = 1, and 0 when fill mode = 0.
  - Enter DONE on the edge where remaining becomes 0.
- DONE:
  - out_valid = 1, out_data = working register.
  - On out_ready: return to IDLE. The controller does not accept a new request in that same cycle.
- Latency: out_valid is observed 1 + ceil(amt/2) cycles after the accept edge. amt = 0 gives 1 cycle; amt = 15 gives 9 cycles.
- Only one operation is in flight. in_ready = 0 in SHIFT and DONE, and in_valid is ignored there.
- Backpressure: out_data and out_valid stay stable in DONE until out_ready; no limit on how long this lasts.
- Inputs (in_data, in_amt, in_arith) are sampled only at accept; changes during SHIFT have no effect.
- Arithmetic fill of a negative operand shifted by WIDTH-1 gives all ones. Logical fill gives 0 or 1 (the original MSB).
- Reset during SHIFT or DONE: the operation is dropped and no out_valid is produced; all registers return to reset values.

Optional Feature:
- Macro ITER_SHIFT_ROTATE_EN.
- Defined:
  - Adds input port in_rot (1 bit), latched at accept.
  - When in_rot = 1, vacated MSBs take the bits shifted out of the LSBs (rotate right), and in_arith is ignored.
  - Latency is the same as for shifts.
- Undefined: port absent; shift-only behaviour as above.

Decomposition:
- Package iter_shift_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - localparams for the per-cycle step sizes (2 and 1);
  - fill-mode encoding.
- One sub-module, shr_step: combinational, WIDTH-bit right shift by 1 or 2.
  - Inputs: data, sel2, fill bit; plus, under the macro, rotate.
  - Instantiated once inside iter_shift_ctrl.

Test Plan:
- in_data = 0x8000, amt = 4, arith = 1, out_ready = 1 -> out_data = 0xF800. out_valid exactly 3 cycles after accept, busy high throughout.
- in_data = 0x8000, amt = 3, arith = 0 -> out_data = 0x1000 after 2 shift cycles (step 2, then step 1); out_valid 3 cycles after accept.
- in_data = 0x1234, amt = 0 -> out_data = 0x1234, out_valid 1 cycle after accept; in_valid held high during DONE is not accepted.
- in_data = 0x8001, amt = 15, arith = 1, out_ready held 0 for 5 cycles -> out_data = 0xFFFF stable and out_valid held until out_ready; in_ready returns 1 the cycle after handshake.
- rst_n pulsed low mid-SHIFT (amt = 15, cycle 3) -> immediate IDLE, out_valid = 0, out_data = 0; a following request amt = 2, data 0x0004 yields 0x0001.
- With ITER_SHIFT_ROTATE_EN: data 0x0001, amt = 2, in_rot = 1 -> 0x4000; data 0x00F1, amt = 5 -> 0x8807.

Source files
------------

// File: rtl/iter_shift_pkg.sv
// Shared types and step constants for the iterative right-shift controller.
package iter_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int STEP_BIG   = 2;
  localparam int STEP_SMALL = 1;

  typedef enum logic {
    FILL_ZERO = 1'b0,
    FILL_SIGN = 1'b1
  } fill_t;

endpackage

// File: rtl/shr_step.sv
// Combinational right shift by 1 or 2 with a supplied fill bit.
// With ITER_SHIFT_ROTATE_EN defined, a rotate input recirculates the LSBs instead.
module shr_step
  import iter_shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  input  logic             sel2,
  input  logic             fill,
`ifdef ITER_SHIFT_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] result
);

  logic       rot;
  logic [1:0] top2;
  logic       top1;

`ifdef ITER_SHIFT_ROTATE_EN
  assign rot = rotate;
`else
  assign rot = 1'b0;
`endif

  always_comb begin
    top2 = rot ? data[STEP_BIG-1:0] : {fill, fill};
    top1 = rot ? data[0] : fill;
    if (sel2) begin
      result = {top2, data[WIDTH-1:STEP_BIG]};
    end else begin
      result = {top1, data[WIDTH-1:STEP_SMALL]};
    end
  end

endmodule

// File: rtl/iter_shift_ctrl.sv
// Multi-cycle right shifter: one shared step per cycle, 1 + ceil(amt/2) cycles from accept to out_valid.
// One op in flight; result held in DONE until out_ready. ITER_SHIFT_ROTATE_EN adds in_rot (rotate right).
module iter_shift_ctrl
  import iter_shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMTW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMTW-1:0]  in_amt,
  input  logic             in_arith,
`ifdef ITER_SHIFT_ROTATE_EN
  input  logic             in_rot,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt, step_out;
  logic [AMTW-1:0]  rem, rem_nxt;
  fill_t            fill_mode, fill_mode_nxt;
  logic             sel2;
  logic             fill_bit;
`ifdef ITER_SHIFT_ROTATE_EN
  logic             rot_mode, rot_mode_nxt;
`endif

  assign sel2     = (rem >= AMTW'(STEP_BIG));
  // Sign fill replicates the current MSB, which never changes under sign fill.
  assign fill_bit = (fill_mode == FILL_SIGN) && work[WIDTH-1];

  shr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data   (work),
    .sel2   (sel2),
    .fill   (fill_bit),
`ifdef ITER_SHIFT_ROTATE_EN
    .rotate (rot_mode),
`endif
    .result (step_out)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = work;

  always_comb begin
    state_nxt     = state;
    work_nxt      = work;
    rem_nxt       = rem;
    fill_mode_nxt = fill_mode;
`ifdef ITER_SHIFT_ROTATE_EN
    rot_mode_nxt  = rot_mode;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          work_nxt      = in_data;
          rem_nxt       = in_amt;
          fill_mode_nxt = fill_t'(in_arith);
`ifdef ITER_SHIFT_ROTATE_EN
          rot_mode_nxt  = in_rot;
`endif
          state_nxt     = (in_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        work_nxt = step_out;
        rem_nxt  = rem - (sel2 ? AMTW'(STEP_BIG) : AMTW'(STEP_SMALL));
        if (rem_nxt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      rem       <= '0;
      fill_mode <= FILL_ZERO;
`ifdef ITER_SHIFT_ROTATE_EN
      rot_mode  <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      work      <= work_nxt;
      rem       <= rem_nxt;
      fill_mode <= fill_mode_nxt;
`ifdef ITER_SHIFT_ROTATE_EN
      rot_mode  <= rot_mode_nxt;
`endif
    end
  end

endmodule
